// File: rtl/reg_access_master_if.sv
// Command, register-port and response signals of the register access master.
// The master modport is the sequencer; the slave modport is its surroundings.
interface reg_access_master_if #(
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_port;
  logic [DATA_W-1:0] cmd_data;
  logic              reg_wr_en_1;
  logic [DATA_W-1:0] reg_wr_data_1;
  logic              reg_wr_en_2;
  logic [DATA_W-1:0] reg_wr_data_2;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [7:0]        err_cnt;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_port, cmd_data, reg_rd_data, rsp_ready,
    output cmd_ready, reg_wr_en_1, reg_wr_data_1, reg_wr_en_2, reg_wr_data_2,
           reg_rd_en, rsp_valid, rsp_data, rsp_err, err_cnt, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_port, cmd_data, reg_rd_data, rsp_ready,
    input  cmd_ready, reg_wr_en_1, reg_wr_data_1, reg_wr_en_2, reg_wr_data_2,
           reg_rd_en, rsp_valid, rsp_data, rsp_err, err_cnt, busy
  );
endinterface

// File: rtl/reg_access_master.sv
// Single-command sequencer for a dual-write-port, single-read-port register:
// write, optional read-back verify, and a held response with error counting.
module reg_access_master #(
  parameter int DATA_W    = 16,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_access_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, RDBK, RESP} state_t;

  state_t            state;
  logic              wr_p0;
  logic              port_p0;
  logic [DATA_W-1:0] data_p0;
  logic              mismatch;

  logic              cmd_ready_q;
  logic              wr_en_1_q;
  logic [DATA_W-1:0] wr_data_1_q;
  logic              wr_en_2_q;
  logic [DATA_W-1:0] wr_data_2_q;
  logic              rd_en_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [7:0]        err_cnt_q;
  logic              busy_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign mismatch = wr_p0 && (bus.reg_rd_data != data_p0);

  // Accepted command held for the whole transaction
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cmd_valid) begin
      wr_p0   <= bus.cmd_write;
      port_p0 <= bus.cmd_port;
      data_p0 <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b1;
      wr_en_1_q   <= 1'b0;
      wr_data_1_q <= '0;
      wr_en_2_q   <= 1'b0;
      wr_data_2_q <= '0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_write) begin
              state       <= WRITE;
              wr_en_1_q   <= !bus.cmd_port;
              wr_data_1_q <= bus.cmd_port ? '0 : bus.cmd_data;
              wr_en_2_q   <= bus.cmd_port;
              wr_data_2_q <= bus.cmd_port ? bus.cmd_data : '0;
            end else begin
              state   <= RDBK;
              rd_en_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en_1_q   <= 1'b0;
          wr_data_1_q <= '0;
          wr_en_2_q   <= 1'b0;
          wr_data_2_q <= '0;
          if (VERIFY_EN) begin
            state   <= RDBK;
            rd_en_q <= 1'b1;
          end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= data_p0;
            rsp_err_q   <= 1'b0;
          end
        end
        RDBK: begin
          // Register output is combinational while rd_en is high; capture it here
          state       <= RESP;
          rd_en_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= bus.reg_rd_data;
          rsp_err_q   <= mismatch;
          if (mismatch) err_cnt_q <= sat_inc(err_cnt_q);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.reg_wr_en_1   = wr_en_1_q;
  assign bus.reg_wr_data_1 = wr_data_1_q;
  assign bus.reg_wr_en_2   = wr_en_2_q;
  assign bus.reg_wr_data_2 = wr_data_2_q;
  assign bus.reg_rd_en     = rd_en_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.busy          = busy_q;

endmodule

// File: doc/reg_access_master.md
Name: reg_access_master

Overview:
Initiator-side sequencer for the 16-bit dual-write-port, single-read-port register block. It accepts one read or write command at a time over a valid/ready handshake. It drives the register's write-port and read-enable signals and optionally reads back every write to verify it. Results return over a valid/ready response channel. It sits between the control datapath and each register instance, so upstream logic never toggles register ports directly.

Parameters:
DATA_W, 16, width of command, register and response data.
VERIFY_EN, 1, 1 = every write is followed by a read-back compare; 0 = writes respond immediately with no read-back.

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  master can accept a command.
cmd_write  in  1  1 = write, 0 = read.
cmd_port  in  1  write target: 0 = port 1, 1 = port 2; ignored for reads.
cmd_data  in  DATA_W  write data; ignored for reads.
reg_wr_en_1  out  1  write enable, register port 1.
reg_wr_data_1  out  DATA_W  write data, register port 1.
reg_wr_en_2  out  1  write enable, register port 2.
reg_wr_data_2  out  DATA_W  write data, register port 2.
reg_rd_en  out  1  read enable to the register; register output is valid combinationally while this is high.
reg_rd_data  in  DATA_W  register read data.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  DATA_W  read data, or read-back data (or written data when VERIFY_EN = 0).
rsp_err  out  1  read-back mismatch on a write.
err_cnt  out  8  saturating mismatch count.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, immediate, including mid-command):
  - FSM goes to IDLE.
  - cmd_ready = 1.
  - All enables = 0, all data outputs = 0.
  - rsp_valid = 0, rsp_err = 0, err_cnt = 0, busy = 0.
  - Any in-flight command is dropped and no response is produced.
- Outputs are Moore decodes of the state register plus holding registers. There is no combinational path from any input to any output.
- FSM states: IDLE, WRITE, RDBK, RESP.
  - IDLE: cmd_ready = 1. On the edge where cmd_valid & cmd_ready, latch cmd_write, cmd_port and cmd_data. Next state is WRITE if cmd_write, else RDBK.
  - WRITE: exactly one cycle. Assert the selected reg_wr_en_x = 1 and drive reg_wr_data_x = latched data.
    - The unselected port's enable and data stay 0.
    - Both enables are never high together.
    - Next state is RDBK if VERIFY_EN, else RESP with rsp_data = latched data and rsp_err = 0.
  - RDBK: exactly one cycle with reg_rd_en = 1. At the closing edge:
    - rsp_data <= reg_rd_data.
    - rsp_err <= write command AND (reg_rd_data != latched data); always 0 for reads.
    - err_cnt increments on a mismatch, saturating at 255.
    - Next state is RESP.
  - RESP: rsp_valid = 1. rsp_data and rsp_err are held stable until rsp_ready is sampled high. Then go to IDLE and clear rsp_valid.
- reg_wr_data_x is 0 whenever its enable is low. reg_rd_en is 0 outside RDBK.
- cmd_ready = 0 in WRITE, RDBK and RESP. There is no command pipelining and no skid buffer.
  - Back-to-back throughput is 1 command per 3 cycles (read) or 4 cycles (verified write) when rsp_ready is held high.
- Latency, counted from the accept edge T0:
  - Read: rsp_valid high from T1.
  - Verified write: write cycle T0–T1, read-back T1–T2, rsp_valid high from T2.
  - Unverified write: rsp_valid high from T1.
- rsp_ready asserted outside RESP has no effect.
- cmd_valid may drop without acceptance; the master does nothing.
- A write becomes visible in the register at the edge closing WRITE, so read-back in the next cycle observes it.

Test Plan:
1. Assert reset for 2 cycles, then release with cmd_valid = 0 → cmd_ready = 1, all enables 0, rsp_valid = 0, err_cnt = 0, busy = 0.
2. Write port 1, data 0xA5A5, VERIFY_EN = 1, echoing register model → reg_wr_en_1 = 1 for exactly one cycle with data 0xA5A5 and reg_wr_en_2 = 0. reg_rd_en pulses once the next cycle. rsp_valid rises at T2 with rsp_data = 0xA5A5, rsp_err = 0.
3. Write port 2, data 0x1234, with a model that returns 0x1230 → rsp_err = 1, rsp_data = 0x1230, err_cnt = 1. Repeat 300 times → err_cnt saturates at 255.
4. Preload the model to 0xBEEF, then issue a read → no write enables; rsp_valid at T1 with rsp_data = 0xBEEF, rsp_err = 0. Repeat with VERIFY_EN = 0 write 0x00FF → rsp_valid at T1, no reg_rd_en pulse.
5. Hold rsp_ready low for 5 cycles with cmd_valid held high → rsp_valid, rsp_data and rsp_err stay stable and cmd_ready = 0. The second command is accepted only on the cycle after rsp_ready is sampled high.
6. Assert reset during WRITE (reg_wr_en_1 high) → enable drops immediately without waiting for a clock edge. After release: IDLE, no response, err_cnt = 0, and the next command runs normally.
